// File: rtl/fma_ui_pkg.sv
// Shared definitions for the BF16 FMA front-panel entry logic.
//
// Contents:
//   BF16_W, CURSOR_W, NUM_BTN   widths and button count
//   BTN_*                       bit positions of the buttons in the debounced vectors
//   ui_state_e                  operand-entry state; its encoding is driven out as op_sel
//   ui_action_e                 single arbitrated action per cycle
//   nibble_step()               +/-1 (mod 16) on one nibble of a word
package fma_ui_pkg;

    localparam int unsigned BF16_W   = 16;
    localparam int unsigned CURSOR_W = 2;
    localparam int unsigned NUM_BTN  = 5;

    localparam int unsigned BTN_RIGHT = 0;
    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_ENTER = 4;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ENTER_C = 2'd2,
        DONE    = 2'd3
    } ui_state_e;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_ENTER,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } ui_action_e;

    // Increment or decrement nibble idx of word, wrapping within the nibble.
    function automatic logic [BF16_W-1:0] nibble_step(input logic [BF16_W-1:0]   word,
                                                      input logic [CURSOR_W-1:0] idx,
                                                      input logic                inc);
        logic [BF16_W-1:0] res;
        logic [3:0]        nib;
        res = word;
        nib = word[{idx, 2'b00} +: 4];
        nib = inc ? nib + 4'd1 : nib - 4'd1;
        res[{idx, 2'b00} +: 4] = nib;
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single pushbutton conditioner: 2-FF synchronizer, mismatch counter, debounced
// level and a one-cycle press pulse on its rising edge.
//
// Ports:
//   clk_100MHz  in   system clock
//   reset       in   asynchronous, active-high
//   btn_raw     in   raw asynchronous button
//   btn_level   out  debounced (stable) level
//   btn_pulse   out  one-cycle pulse, DEBOUNCE_CYCLES+3 edges after a clean rise
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             armed_q;
    logic             pulse_q;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == LAST_CNT) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // The synchronizer resets to "pressed" so a button held through reset never
    // looks like a fresh press; armed_q only sets once a genuine low is sampled.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync_q       <= 2'b11;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            armed_q      <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_raw};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            armed_q      <= armed_q | ~sync_q[1];
            pulse_q      <= stable_q & ~stable_dly_q & armed_q;
        end
    end

    assign btn_level = stable_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/operand_entry_ctrl.sv
// Front-panel operand entry for the BF16 FMA demo. Five debounced buttons edit a
// 16-bit hex word nibble by nibble; enter commits A, B then C and fires start.
// edit_data/disp_write follow the hex display's data_in/dm_write format.
//
// Build option: define ENTRY_AUTOREPEAT_EN to auto-repeat held up/down buttons
// (first repeat HOLD_CYCLES after the press, then every REPEAT_CYCLES).
//
// Ports:
//   clk_100MHz, reset            clock; asynchronous active-high reset
//   btn_up/down/left/right/enter raw buttons
//   edit_data   out  word under edit
//   disp_write  out  strobe in the cycle edit_data takes a new value
//   cursor      out  nibble index under edit (0 = bits 3:0)
//   op_sel      out  0 = A, 1 = B, 2 = C, 3 = done
//   op_a/b/c    out  committed operands
//   start       out  one-cycle pulse after op_c is committed
module operand_entry_ctrl
    import fma_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic                clk_100MHz,
    input  logic                reset,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_enter,
    output logic [BF16_W-1:0]   edit_data,
    output logic                disp_write,
    output logic [CURSOR_W-1:0] cursor,
    output logic [1:0]          op_sel,
    output logic [BF16_W-1:0]   op_a,
    output logic [BF16_W-1:0]   op_b,
    output logic [BF16_W-1:0]   op_c,
    output logic                start
);

    logic [NUM_BTN-1:0] btn_raw, btn_level, deb_pulse, press_pulse;

    assign btn_raw = {btn_enter, btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_100MHz(clk_100MHz),
            .reset     (reset),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_level[i]),
            .btn_pulse (deb_pulse[i])
        );
    end

`ifdef ENTRY_AUTOREPEAT_EN
    logic [1:0] rep_fire;

    for (genvar r = 0; r < 2; r++) begin : g_rep
        localparam int unsigned IDX = (r == 0) ? BTN_UP : BTN_DOWN;
        logic [31:0] rep_cnt_q;
        logic        rep_first_q;
        logic [31:0] limit;

        // rep_cnt_q counts cycles since the last (initial or repeated) pulse; 0 = idle.
        assign limit       = rep_first_q ? HOLD_CYCLES : REPEAT_CYCLES;
        assign rep_fire[r] = btn_level[IDX] && (rep_cnt_q == limit);

        always_ff @(posedge clk_100MHz or posedge reset) begin
            if (reset) begin
                rep_cnt_q   <= '0;
                rep_first_q <= 1'b1;
            end else if (!btn_level[IDX]) begin
                rep_cnt_q   <= '0;
                rep_first_q <= 1'b1;
            end else if (deb_pulse[IDX]) begin
                rep_cnt_q   <= 32'd1;
                rep_first_q <= 1'b1;
            end else if (rep_fire[r]) begin
                rep_cnt_q   <= 32'd1;
                rep_first_q <= 1'b0;
            end else if (rep_cnt_q != '0) begin
                rep_cnt_q   <= rep_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        press_pulse         = deb_pulse;
        press_pulse[BTN_UP]   = deb_pulse[BTN_UP] | rep_fire[0];
        press_pulse[BTN_DOWN] = deb_pulse[BTN_DOWN] | rep_fire[1];
    end
`else
    assign press_pulse = deb_pulse;

    logic unused_repeat;
    assign unused_repeat = ^{btn_level, HOLD_CYCLES, REPEAT_CYCLES};
`endif

    // One action per cycle: enter > up > down > left > right.
    ui_action_e act;

    always_comb begin
        act = ACT_NONE;
        if (press_pulse[BTN_ENTER]) begin
            act = ACT_ENTER;
        end else if (press_pulse[BTN_UP]) begin
            act = ACT_UP;
        end else if (press_pulse[BTN_DOWN]) begin
            act = ACT_DOWN;
        end else if (press_pulse[BTN_LEFT]) begin
            act = ACT_LEFT;
        end else if (press_pulse[BTN_RIGHT]) begin
            act = ACT_RIGHT;
        end
    end

    ui_state_e           state_q, state_d;
    logic [BF16_W-1:0]   edit_q, edit_d;
    logic [CURSOR_W-1:0] cursor_q, cursor_d;
    logic [BF16_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic                disp_write_q, disp_write_d;
    logic                start_q, start_d;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (act == ACT_ENTER) begin
            unique case (state_q)
                ENTER_A: state_d = ENTER_B;
                ENTER_B: state_d = ENTER_C;
                ENTER_C: state_d = DONE;
                DONE:    state_d = ENTER_A;
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_comb begin
        edit_d       = edit_q;
        cursor_d     = cursor_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_c_d       = op_c_q;
        disp_write_d = 1'b0;
        start_d      = 1'b0;
        case (act)
            ACT_ENTER: begin
                disp_write_d = 1'b1;
                cursor_d     = '0;
                unique case (state_q)
                    ENTER_A: begin
                        op_a_d = edit_q;
                        edit_d = op_b_q;
                    end
                    ENTER_B: begin
                        op_b_d = edit_q;
                        edit_d = op_c_q;
                    end
                    ENTER_C: begin
                        // edit_data keeps the just-committed op_c on display.
                        op_c_d  = edit_q;
                        start_d = 1'b1;
                    end
                    DONE: begin
                        edit_d = op_a_q;
                    end
                    default: ;
                endcase
            end
            ACT_UP: begin
                if (state_q != DONE) begin
                    edit_d       = nibble_step(edit_q, cursor_q, 1'b1);
                    disp_write_d = 1'b1;
                end
            end
            ACT_DOWN: begin
                if (state_q != DONE) begin
                    edit_d       = nibble_step(edit_q, cursor_q, 1'b0);
                    disp_write_d = 1'b1;
                end
            end
            ACT_LEFT: begin
                if (state_q != DONE) begin
                    cursor_d = cursor_q + 1'b1;
                end
            end
            ACT_RIGHT: begin
                if (state_q != DONE) begin
                    cursor_d = cursor_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            edit_q       <= '0;
            cursor_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= '0;
            disp_write_q <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            edit_q       <= edit_d;
            cursor_q     <= cursor_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_c_q       <= op_c_d;
            disp_write_q <= disp_write_d;
            start_q      <= start_d;
        end
    end

    assign edit_data  = edit_q;
    assign disp_write = disp_write_q;
    assign cursor     = cursor_q;
    assign op_sel     = state_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_c       = op_c_q;
    assign start      = start_q;

endmodule
